axis_uart_tx_arbiter: RTL and testbench

//  Shares one byte-wide UART TX path between N_PORTS AXI-Stream packet sources.

---
 rtl/axis_uart_arb_pkg.sv | 41 ++++
 rtl/uart_rr_picker.sv | 22 ++
 rtl/axis_uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_axis_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_uart_arb_pkg
// Description : Shared types, widths and round-robin helper for the UART TX
//               packet arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_uart_arb_pkg;

    localparam int HDR_TAG_W = 4;
    localparam int PORT_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE_ST    = 2'd0,
        HEADER_ST  = 2'd1,
        PAYLOAD_ST = 2'd2
    } arb_state_t;

    // First requesting port found searching last+1, last+2, ... modulo n.
    function automatic logic [PORT_ID_W-1:0] rr_next(
        input logic [15:0]          req,
        input logic [PORT_ID_W-1:0] last,
        input int                   n
    );
        logic [PORT_ID_W-1:0] pick;
        logic [PORT_ID_W-1:0] idx;
        logic                 found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = PORT_ID_W'((int'(last) + i) % n);
            if (!found && (i <= n) && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_picker
// Description : Combinational rotate-priority encoder for round-robin grants.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_picker
    import axis_uart_arb_pkg::*;
#(
    parameter int N_PORTS = 4
) (
    input  logic [N_PORTS-1:0]   i_req,
    input  logic [PORT_ID_W-1:0] i_last,
    output logic [PORT_ID_W-1:0] o_grant,
    output logic                 o_valid
);

    assign o_grant = rr_next(16'(i_req), i_last, N_PORTS);
    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/axis_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_uart_tx_arbiter
// Description : Round-robin, packet-atomic AXI-Stream arbiter feeding one UART
//               TX serializer; each packet is prefixed with {tag, port_id}.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_uart_tx_arbiter
    import axis_uart_arb_pkg::*;
#(
    parameter int                   N_PORTS       = 4,
    parameter logic [HDR_TAG_W-1:0] HEADER_TAG    = 4'hA,
    parameter int                   MAX_PKT_BYTES = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_PORTS*8-1:0]   S_AXIS_TDATA,
    input  logic [N_PORTS-1:0]     S_AXIS_TVALID,
    input  logic [N_PORTS-1:0]     S_AXIS_TLAST,
    output logic [N_PORTS-1:0]     S_AXIS_TREADY,
    input  logic [N_PORTS-1:0]     PORT_EN,
    output logic [7:0]             M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY,
    output logic [PORT_ID_W-1:0]   GRANT_ID,
    output logic                   BUSY
);

    localparam int                   CNT_W      = $clog2(MAX_PKT_BYTES + 1);
    localparam logic [CNT_W-1:0]     C_CNT_LAST = CNT_W'(MAX_PKT_BYTES - 1);
    localparam logic [PORT_ID_W-1:0] C_LAST_RST = PORT_ID_W'(N_PORTS - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [PORT_ID_W-1:0] r_grant;
    logic [PORT_ID_W-1:0] r_last_grant;
    logic [CNT_W-1:0]     r_byte_cnt;
    logic [PORT_ID_W-1:0] w_pick;
    logic                 w_pick_valid;
    logic [7:0]           w_sel_data;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic                 w_last;
    logic                 w_m_hs;

    uart_rr_picker #(
        .N_PORTS (N_PORTS)
    ) u_picker (
        .i_req   (S_AXIS_TVALID & PORT_EN),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // Granted-source selection
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_grant == PORT_ID_W'(i)) begin
                w_sel_data  = S_AXIS_TDATA[8*i +: 8];
                w_sel_valid = S_AXIS_TVALID[i];
                w_sel_last  = S_AXIS_TLAST[i];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        M_AXIS_TDATA  = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = '0;
        w_last        = 1'b0;
        case (r_state)
            IDLE_ST: begin
                if (w_pick_valid) begin
                    w_state_nxt = HEADER_ST;
                end
            end
            HEADER_ST: begin
                M_AXIS_TDATA  = {HEADER_TAG, r_grant};
                M_AXIS_TVALID = 1'b1;
                if (M_AXIS_TREADY) begin
                    w_state_nxt = PAYLOAD_ST;
                end
            end
            PAYLOAD_ST: begin
                // Byte-count limit forces a packet boundary without eating source TLAST
                w_last        = w_sel_last | (r_byte_cnt == C_CNT_LAST);
                M_AXIS_TDATA  = w_sel_data;
                M_AXIS_TVALID = w_sel_valid;
                M_AXIS_TLAST  = w_last;
                for (int i = 0; i < N_PORTS; i++) begin
                    S_AXIS_TREADY[i] = (r_grant == PORT_ID_W'(i)) & M_AXIS_TREADY;
                end
                if (w_sel_valid && M_AXIS_TREADY && w_last) begin
                    w_state_nxt = IDLE_ST;
                end
            end
            default: begin
                w_state_nxt = IDLE_ST;
            end
        endcase
    end

    assign w_m_hs = M_AXIS_TVALID & M_AXIS_TREADY;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE_ST;
            r_grant      <= '0;
            r_last_grant <= C_LAST_RST;
            r_byte_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE_ST: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick;
                    end
                end
                HEADER_ST: begin
                    r_byte_cnt <= '0;
                end
                PAYLOAD_ST: begin
                    if (w_m_hs) begin
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_last_grant <= r_grant;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign GRANT_ID = r_grant;
    assign BUSY     = (r_state != IDLE_ST);

endmodule
`default_nettype wire

// File: tb/tb_axis_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_uart_tx_arbiter
// Description : Randomized scoreboard bench for axis_uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_uart_tx_arbiter;

    localparam int         N    = 4;
    localparam int         MAXB = 4;
    localparam logic [3:0] TAG  = 4'hA;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*8-1:0] s_tdata;
    logic [N-1:0]   s_tvalid, s_tlast, s_tready, port_en;
    logic [7:0]     m_tdata;
    logic           m_tvalid, m_tlast, m_tready;
    logic [3:0]     grant_id;
    logic           busy;

    axis_uart_tx_arbiter #(
        .N_PORTS       (N),
        .HEADER_TAG    (TAG),
        .MAX_PKT_BYTES (MAXB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .PORT_EN       (port_en),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .GRANT_ID      (grant_id),
        .BUSY          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       hdr;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    exp_t       exp_q[$];
    logic [8:0] pmem[N][64];
    int         rd[N];
    int         wr[N];
    int         model_last;
    int         rdy_mode;
    int         out_hs;
    logic [N-1:0] hs_flag;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic add_byte(int p, logic [7:0] d, logic l);
        pmem[p][wr[p]] = {l, d};
        wr[p]++;
    endtask

    task automatic add_pkt(int p, int len);
        for (int i = 0; i < len; i++) add_byte(p, 8'($urandom), (i == len - 1));
    endtask

    task automatic new_phase();
        for (int p = 0; p < N; p++) begin
            rd[p] = 0;
            wr[p] = 0;
        end
    endtask

    // Reference: serve queued packets in round-robin order, header first,
    // cutting a chunk after MAXB payload bytes.
    task automatic model_expect();
        int         r[N];
        int         p, q, cnt;
        logic [8:0] b;
        logic       lst;
        for (int i = 0; i < N; i++) r[i] = rd[i];
        forever begin
            p = -1;
            for (int k = 1; k <= N; k++) begin
                q = (model_last + k) % N;
                if (p < 0 && r[q] < wr[q] && port_en[q]) p = q;
            end
            if (p < 0) break;
            exp_q.push_back(exp_t'{data: {TAG, 4'(p)}, last: 1'b0, hdr: 1'b1});
            cnt = 0;
            forever begin
                b = pmem[p][r[p]];
                r[p]++;
                cnt++;
                lst = b[8] || (cnt == MAXB);
                exp_q.push_back(exp_t'{data: b[7:0], last: lst, hdr: 1'b0});
                if (lst) break;
            end
            model_last = p;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int p = 0; p < N; p++) if (hs_flag[p]) rd[p]++;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
        for (int p = 0; p < N; p++) begin
            if (rd[p] < wr[p]) begin
                s_tvalid[p]        = 1'b1;
                s_tdata[8*p +: 8]  = pmem[p][rd[p]][7:0];
                s_tlast[p]         = pmem[p][rd[p]][8];
            end else begin
                s_tvalid[p]        = 1'b0;
                s_tdata[8*p +: 8]  = 8'h00;
                s_tlast[p]         = 1'b0;
            end
        end
        #1;
        hs_flag = s_tvalid & s_tready;
        if (m_tvalid && m_tready) out_hs++;
    endtask

    function automatic bit all_done();
        bit d;
        d = (exp_q.size() == 0) && !busy;
        for (int p = 0; p < N; p++) if (rd[p] < wr[p]) d = 1'b0;
        return d;
    endfunction

    task automatic drain(string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (all_done()) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d busy=%0d expected drained", name, exp_q.size(), busy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        new_phase();
        hs_flag    = '0;
        s_tvalid   = '0;
        s_tlast    = '0;
        s_tdata    = '0;
        model_last = N - 1;
        @(negedge clk);
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
    endtask

    // Monitor: compares every output handshake against the scoreboard.
    initial begin
        exp_t       e;
        logic       pv_stall;
        logic [7:0] pdata;
        pv_stall = 1'b0;
        pdata    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                pv_stall = 1'b0;
            end else begin
                if (pv_stall) begin
                    check("stall_valid", m_tvalid, 1);
                    check("stall_data", m_tdata, pdata);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %0h expected none", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_tdata, e.data);
                        check("out_last", m_tlast, e.last);
                        if (e.hdr) begin
                            check("hdr_grant_id", grant_id, e.data[3:0]);
                            check("hdr_busy", busy, 1);
                        end
                    end
                end
                pv_stall = m_tvalid && !m_tready;
                pdata    = m_tdata;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        port_en    = '1;
        m_tready   = 1'b0;
        s_tvalid   = '0;
        s_tlast    = '0;
        s_tdata    = '0;
        hs_flag    = '0;
        rdy_mode   = 0;
        out_hs     = 0;
        model_last = N - 1;
        new_phase();
        repeat (2) @(negedge clk);
        do_reset();

        // Basic 3-byte packet from port 0
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h22, 1'b0);
        add_byte(0, 8'h33, 1'b1);
        model_expect();
        drain("t1");

        // Ports 1 and 3 contend with single-byte packets
        new_phase();
        add_pkt(1, 1); add_pkt(1, 1);
        add_pkt(3, 1); add_pkt(3, 1);
        model_expect();
        drain("t2");

        // Forced TLAST split of a 6-byte packet
        new_phase();
        add_pkt(2, 6);
        model_expect();
        drain("t3");

        // Alternating backpressure
        new_phase();
        rdy_mode = 1;
        add_pkt(0, 5);
        model_expect();
        drain("t4");

        // Masked requester is never granted until enabled
        new_phase();
        rdy_mode = 0;
        port_en  = 4'b1101;
        add_pkt(1, 2);
        for (int c = 0; c < 10; c++) begin
            step();
            check("mask_busy", busy, 0);
            check("mask_valid", m_tvalid, 0);
        end
        port_en = '1;
        model_expect();
        drain("t5");

        // Reset in the middle of a payload
        new_phase();
        add_pkt(2, 4);
        model_expect();
        out_hs = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (out_hs >= 2) break;
        end
        check("t6_reach_payload", out_hs, 2);
        do_reset();
        add_pkt(0, 1);
        model_expect();
        drain("t6");

        // Randomized traffic, starting fresh so port 0 has first priority
        do_reset();
        rdy_mode = 2;
        for (int round = 0; round < 6; round++) begin
            new_phase();
            for (int p = 0; p < N; p++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int k = 0; k < np; k++) add_pkt(p, $urandom_range(1, 6));
            end
            model_expect();
            drain("rand");
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
